pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the `en` and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves four conditions:
- load-use hazards
- taken branch/JR redirects resolved at EX/MEM
- multi-cycle data-memory stalls
- the HALT (dump) drain sequence

It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- DRAIN_CYCLES, 2, cycles EX/MEM and MEM/WB keep advancing after dump is seen, before freezing.
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- idex_mem_to_reg  in  1  ID/EX instruction is a load.
- idex_reg_write  in  1  ID/EX instruction writes a register.
- idex_reg_wr_sel  in  3  ID/EX destination register.
- ifid_rs, ifid_rt  in  3 each  IF/ID source registers.
- ifid_rs_vld, ifid_rt_vld  in  1 each  source actually read.
- exmem_branch_cond  in  1  taken branch resolved in EX/MEM.
- exmem_jr  in  1  JR/JALR in EX/MEM.
- exmem_dump  in  1  HALT in EX/MEM.
- mem_stall  in  1  data memory not ready this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control zero) on next edge.
- pc_redirect  out  1  PC mux selects EX/MEM branch/JR target.
- halted  out  1  pipeline frozen after HALT.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT.

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. The state register and the drain counter are the only sequential state besides stall_cycles.
- While rst=0:
  - state=RUN, drain count=0, stall_cycles=0, halted=0.
  - All enables, flushes and pc_redirect are 0.
- Outputs are Mealy: combinational from the current state and the current inputs.

RUN, condition priority (highest first):
1. mem_stall=1 → all five enables 0, no flushes, pc_redirect=0; next state MEM_WAIT.
2. exmem_dump=1 → pc_en=0, ifid_flush=1, idex_flush=1, exmem_en=memwb_en=1; load drain count=DRAIN_CYCLES-1; next state DRAIN. Any redirect is ignored.
3. exmem_branch_cond|exmem_jr → pc_redirect=1, all enables 1, ifid_flush=idex_flush=exmem_flush=1. This squashes the three younger instructions.
4. Load-use: idex_mem_to_reg & idex_reg_write & ((ifid_rs_vld & ifid_rs==idex_reg_wr_sel) | (ifid_rt_vld & ifid_rt==idex_reg_wr_sel)) → pc_en=ifid_en=0, idex_flush=1, others enabled. Lasts exactly one cycle, because the bubble clears the match.
5. Otherwise all enables 1, no flushes.

Other states:
- MEM_WAIT: all enables 0 while mem_stall=1. When mem_stall=0, evaluate as RUN (priorities 2–5) in the same cycle and go to the RUN next state. A redirect pending in the frozen EX/MEM is therefore taken on the release cycle.
- DRAIN: pc_en=ifid_en=idex_en=0, idex_flush=1, exmem_flush=1, memwb_en=1.
  - mem_stall=1 freezes everything and holds the count.
  - Otherwise decrement; at count 0 go to HALTED.
- HALTED: all enables 0, halted=1. Exit only by reset.
- stall_cycles increments whenever state∈{RUN,MEM_WAIT} and pc_en=0, and saturates at all-ones.
- Flush wins over enable for the same register: a flushed register loads a bubble even when its en=1.

## Timing
- Zero-cycle control latency: enables and flushes respond in the same cycle as the hazard input.
- State and counter update on the rising edge of clk.
- Load-use costs exactly 1 bubble. A taken branch/JR costs 3 squashed slots. A memory stall of N cycles freezes the pipeline for exactly N cycles.
- HALT: dump reaches MEM/WB after DRAIN_CYCLES cycles in DRAIN (excluding mem-stall cycles). halted rises on the following edge.
- rst deassertion is asynchronous to the FSM. The first active edge sees state RUN.
- Reset mid-stall or mid-drain returns to RUN immediately, with the counter cleared.

## Test plan
- Load-use: ID/EX load to r3, IF/ID reads rs=r3 (vld) → one cycle with pc_en=ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cycles=1.
- Taken branch: exmem_branch_cond=1 for 1 cycle → pc_redirect=1 and all three flushes 1 that cycle only; no stall counted.
- Memory stall: mem_stall=1 for 4 cycles with exmem_jr=1 → enables 0 for 4 cycles, pc_redirect=0; on the 5th cycle pc_redirect=1; stall_cycles=4.
- Priority: dump=1 together with branch_cond=1 → no redirect, DRAIN entered; halted=1 after 2 further edges; all enables 0 thereafter.
- Reset mid-DRAIN (rst=0 asynchronously) → halted=0, stall_cycles=0, outputs 0 during reset; normal RUN after release.
- Saturation: hold a load-use stall source for 2^CNT_W+5 cycles (CNT_W=4 build) → stall_cycles sticks at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Handles load-use, EX/MEM redirects, memory stalls and the HALT drain.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_mem_to_reg,
    input  logic             idex_reg_write,
    input  logic [2:0]       idex_reg_wr_sel,
    input  logic [2:0]       ifid_rs,
    input  logic [2:0]       ifid_rt,
    input  logic             ifid_rs_vld,
    input  logic             ifid_rt_vld,
    input  logic             exmem_branch_cond,
    input  logic             exmem_jr,
    input  logic             exmem_dump,
    input  logic             mem_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_redirect,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;
    localparam logic [1:0] HALTED   = 2'd3;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_nxt;
    logic          load_use;
    logic          redirect;

    assign load_use = idex_mem_to_reg & idex_reg_write &
                      ((ifid_rs_vld & (ifid_rs == idex_reg_wr_sel)) |
                       (ifid_rt_vld & (ifid_rt == idex_reg_wr_sel)));
    assign redirect = exmem_branch_cond | exmem_jr;

    assign halted = (state == HALTED);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_redirect = 1'b0;
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        // Outputs are held quiet for the whole reset window
        if (rst) begin
            unique case (state)
                RUN, MEM_WAIT: begin
                    if (mem_stall) begin
                        state_nxt = MEM_WAIT;
                    end else begin
                        state_nxt = RUN;
                        if (exmem_dump) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                            drain_nxt  = DRAIN_LOAD;
                            state_nxt  = DRAIN;
                        end else if (redirect) begin
                            pc_redirect = 1'b1;
                            pc_en       = 1'b1;
                            ifid_en     = 1'b1;
                            idex_en     = 1'b1;
                            exmem_en    = 1'b1;
                            memwb_en    = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                        end else if (load_use) begin
                            idex_en    = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                            idex_flush = 1'b1;
                        end else begin
                            pc_en    = 1'b1;
                            ifid_en  = 1'b1;
                            idex_en  = 1'b1;
                            exmem_en = 1'b1;
                            memwb_en = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!mem_stall) begin
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_en    = 1'b1;
                        if (drain_cnt == '0) begin
                            state_nxt = HALTED;
                        end else begin
                            drain_nxt = drain_cnt - DW'(1);
                        end
                    end
                end
                HALTED: begin
                    state_nxt = HALTED;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((state == RUN || state == MEM_WAIT) && !pc_en &&
                     stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
